// File: rtl/pll_cfg_sequencer.sv
// Sequences fractional-PLL reconfiguration between the NTSC and PAL clock profiles over the
// reconfig core's Avalon-MM port, holding the downstream core in reset until the PLL relocks.
module pll_cfg_sequencer #(
    parameter logic [15:0] M_NTSC       = 16'h0404,
    parameter logic [31:0] K_NTSC       = 32'd2537933971,
    parameter logic [15:0] M_PAL        = 16'h0404,
    parameter logic [31:0] K_PAL        = 32'd2201376125,
    parameter logic [23:0] LOCK_TIMEOUT = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_req,
    input  logic        cfg_sel,
    input  logic        pll_locked,
    input  logic        mgmt_waitrequest,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic        busy,
    output logic        hold_reset,
    output logic        cur_sel,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, WR_MODE, WR_M, WR_K, WR_START, WAIT_LOCK
    } state_t;

    state_t      state, state_d;
    logic        locked_s1, locked_s2;
    logic        tgt, tgt_d;
    logic        pend_vld, pend_vld_d, pend_sel, pend_sel_d;
    logic [23:0] tcnt, tcnt_d;
    logic [4:0]  filt, filt_d;
    logic        seen_low, seen_low_d;
    logic [5:0]  addr_d;
    logic [31:0] data_d;
    logic        write_d, busy_d, hold_d, cur_d, done_d, err_d;
    logic        req_now, req_sel, lock_ok;

    assign mgmt_read = 1'b0;

    always_comb begin
        state_d    = state;
        tgt_d      = tgt;
        pend_vld_d = pend_vld;
        pend_sel_d = pend_sel;
        tcnt_d     = tcnt;
        filt_d     = filt;
        seen_low_d = seen_low;
        addr_d     = mgmt_address;
        data_d     = mgmt_writedata;
        write_d    = mgmt_write;
        busy_d     = busy;
        hold_d     = hold_reset;
        cur_d      = cur_sel;
        done_d     = 1'b0;
        err_d      = 1'b0;
        lock_ok    = 1'b0;
        // A fresh request in the same IDLE cycle supersedes the pending one
        req_now    = cfg_req || pend_vld;
        req_sel    = cfg_req ? cfg_sel : pend_sel;

        if (state != IDLE && cfg_req) begin
            pend_vld_d = 1'b1;
            pend_sel_d = cfg_sel;
        end

        case (state)
            IDLE: begin
                pend_vld_d = 1'b0;
                if (req_now) begin
                    if (req_sel != cur_sel) begin
                        tgt_d   = req_sel;
                        busy_d  = 1'b1;
                        hold_d  = 1'b1;
                        write_d = 1'b1;
                        addr_d  = 6'h00;
                        data_d  = 32'd0;
                        state_d = WR_MODE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WR_MODE, WR_M, WR_K, WR_START: begin
                if (!mgmt_write) begin
                    // Gap cycle is over: launch this state's write
                    write_d = 1'b1;
                    case (state)
                        WR_M: begin
                            addr_d = 6'h04;
                            data_d = {16'h0, (tgt ? M_PAL : M_NTSC)};
                        end
                        WR_K: begin
                            addr_d = 6'h07;
                            data_d = tgt ? K_PAL : K_NTSC;
                        end
                        WR_START: begin
                            addr_d = 6'h02;
                            data_d = 32'd1;
                        end
                        default: begin
                            addr_d = 6'h00;
                            data_d = 32'd0;
                        end
                    endcase
                end else if (!mgmt_waitrequest) begin
                    write_d = 1'b0;
                    case (state)
                        WR_MODE: state_d = WR_M;
                        WR_M:    state_d = WR_K;
                        WR_K:    state_d = WR_START;
                        default: begin
                            state_d    = WAIT_LOCK;
                            tcnt_d     = 24'd0;
                            filt_d     = 5'd0;
                            seen_low_d = 1'b0;
                        end
                    endcase
                end
            end
            WAIT_LOCK: begin
                if (tcnt != LOCK_TIMEOUT) tcnt_d = tcnt + 24'd1;
                // Only a low-then-stable-high lock counts, so a stale lock from the old profile is ignored
                if (!locked_s2) begin
                    seen_low_d = 1'b1;
                    filt_d     = 5'd0;
                end else if (seen_low) begin
                    filt_d = filt + 5'd1;
                    if (filt == 5'd15) lock_ok = 1'b1;
                end
                if (lock_ok) begin
                    cur_d   = tgt;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    hold_d  = 1'b0;
                    state_d = IDLE;
                end else if (tcnt_d == LOCK_TIMEOUT) begin
                    err_d   = 1'b1;
                    cur_d   = tgt;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            locked_s1      <= 1'b0;
            locked_s2      <= 1'b0;
            tgt            <= 1'b0;
            pend_vld       <= 1'b0;
            pend_sel       <= 1'b0;
            tcnt           <= 24'd0;
            filt           <= 5'd0;
            seen_low       <= 1'b0;
            mgmt_address   <= 6'h00;
            mgmt_writedata <= 32'd0;
            mgmt_write     <= 1'b0;
            busy           <= 1'b0;
            hold_reset     <= 1'b0;
            cur_sel        <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            state          <= state_d;
            locked_s1      <= pll_locked;
            locked_s2      <= locked_s1;
            tgt            <= tgt_d;
            pend_vld       <= pend_vld_d;
            pend_sel       <= pend_sel_d;
            tcnt           <= tcnt_d;
            filt           <= filt_d;
            seen_low       <= seen_low_d;
            mgmt_address   <= addr_d;
            mgmt_writedata <= data_d;
            mgmt_write     <= write_d;
            busy           <= busy_d;
            hold_reset     <= hold_d;
            cur_sel        <= cur_d;
            done           <= done_d;
            err            <= err_d;
        end
    end

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Directed bench for pll_cfg_sequencer: bus write log, stall stability, lock filter,
// timeout, pending requests and mid-sequence reset, with hand-computed expectations.
module tb_pll_cfg_sequencer;

    localparam logic [15:0] M_NTSC  = 16'h0404;
    localparam logic [31:0] K_NTSC  = 32'd2537933971;
    localparam logic [15:0] M_PAL   = 16'h0404;
    localparam logic [31:0] K_PAL   = 32'd2201376125;
    localparam logic [23:0] TIMEOUT = 24'd300;

    logic        clk = 1'b0;
    logic        rst, cfg_req, cfg_sel, pll_locked, mgmt_waitrequest;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write, mgmt_read, busy, hold_reset, cur_sel, done, err;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc_idx = 0;
    int wr_hi = 0;
    int stall_cnt = 0;
    logic stall_mode = 1'b0;
    logic prev_stall = 1'b0;
    logic [5:0]  prev_addr;
    logic [31:0] prev_data;
    logic [5:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];

    pll_cfg_sequencer #(
        .M_NTSC(M_NTSC), .K_NTSC(K_NTSC), .M_PAL(M_PAL), .K_PAL(K_PAL),
        .LOCK_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
        .pll_locked(pll_locked), .mgmt_waitrequest(mgmt_waitrequest),
        .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .mgmt_write(mgmt_write), .mgmt_read(mgmt_read), .busy(busy),
        .hold_reset(hold_reset), .cur_sel(cur_sel), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Bus monitor: sample mid-cycle, what the DUT will see at the next rising edge
    always @(negedge clk) begin
        cyc_idx++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stable_write", mgmt_write, 1'b1);
                chk("stable_addr", mgmt_address, prev_addr);
                chk("stable_data", mgmt_writedata, prev_data);
            end
            if (mgmt_write) wr_hi++;
            if (mgmt_write && !mgmt_waitrequest) begin
                wq_addr.push_back(mgmt_address);
                wq_data.push_back(mgmt_writedata);
                wq_cyc.push_back(cyc_idx);
            end
            prev_stall = mgmt_write && mgmt_waitrequest;
            prev_addr  = mgmt_address;
            prev_data  = mgmt_writedata;
        end
    end

    // Slave model: in stall mode every write sees 5 waitrequest cycles before acceptance
    initial begin
        mgmt_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode && mgmt_write) begin
                if (stall_cnt < 5) begin
                    mgmt_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    mgmt_waitrequest = 1'b0;
                end
            end else begin
                mgmt_waitrequest = stall_mode;
                stall_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic sel);
        cfg_req = 1'b1;
        cfg_sel = sel;
        tick();
        cfg_req = 1'b0;
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic wait_writes(input int n);
        int k = 0;
        while (wq_addr.size() < n && k < 200) begin
            tick();
            k++;
        end
        chk("wr_reached", wq_addr.size() >= n, 1'b1);
    endtask

    task automatic check_writes(input int base, input logic sel, input int gap);
        logic [5:0]  ea[4];
        logic [31:0] ed[4];
        ea = '{6'h00, 6'h04, 6'h07, 6'h02};
        ed[0] = 32'd0;
        ed[1] = {16'h0, (sel ? M_PAL : M_NTSC)};
        ed[2] = sel ? K_PAL : K_NTSC;
        ed[3] = 32'd1;
        chk("wr_count", wq_addr.size() >= base + 4, 1'b1);
        if (wq_addr.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("wr_addr", wq_addr[base+i], ea[i]);
                chk("wr_data", wq_data[base+i], ed[i]);
                if (i > 0) chk("wr_spacing", wq_cyc[base+i] - wq_cyc[base+i-1], gap);
            end
        end
    endtask

    // Called in the first WAIT_LOCK cycle; lock accepted after 2 sync flops + 16 high samples
    task automatic lock_and_done();
        int cyc = 0;
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("lock_latency", cyc, 18);
        chk("done_busy", busy, 1'b0);
        chk("done_hold", hold_reset, 1'b0);
    endtask

    initial begin
        int k;
        int w0;
        rst = 1'b1;
        cfg_req = 1'b0;
        cfg_sel = 1'b0;
        pll_locked = 1'b1;
        repeat (3) tick();
        chk("rst_write", mgmt_write, 1'b0);
        chk("rst_addr", mgmt_address, 6'h00);
        chk("rst_data", mgmt_writedata, 32'd0);
        chk("rst_read", mgmt_read, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hold", hold_reset, 1'b0);
        chk("rst_cur", cur_sel, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        repeat (4) tick();

        // Basic PAL sequence, no stalls
        clear_log();
        req(1'b1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_hold", hold_reset, 1'b1);
        chk("t1_write", mgmt_write, 1'b1);
        wait_writes(4);
        check_writes(0, 1'b1, 2);
        lock_and_done();
        chk("t1_cur", cur_sel, 1'b1);
        tick();
        chk("t1_done_pulse", done, 1'b0);

        // NTSC with 5 stall cycles per write
        stall_mode = 1'b1;
        clear_log();
        req(1'b0);
        wait_writes(4);
        check_writes(0, 1'b0, 7);
        stall_mode = 1'b0;
        lock_and_done();
        chk("t2_cur", cur_sel, 1'b0);
        repeat (3) tick();
        chk("t2_once", wq_addr.size(), 4);

        // Same profile requested: immediate done, no bus traffic
        clear_log();
        w0 = wr_hi;
        req(1'b0);
        chk("t3_done", done, 1'b1);
        chk("t3_busy", busy, 1'b0);
        repeat (5) tick();
        chk("t3_no_write", wr_hi - w0, 0);
        chk("t3_done_pulse", done, 1'b0);

        // Lock never drops: timeout
        clear_log();
        req(1'b1);
        wait_writes(4);
        k = 0;
        while (!err && k < 400) begin
            tick();
            k++;
        end
        chk("t4_timeout_cycles", k, TIMEOUT);
        chk("t4_hold", hold_reset, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_cur", cur_sel, 1'b1);
        chk("t4_done", done, 1'b0);
        tick();
        chk("t4_err_pulse", err, 1'b0);
        chk("t4_hold_kept", hold_reset, 1'b1);
        clear_log();
        req(1'b0);
        wait_writes(4);
        check_writes(0, 1'b0, 2);
        lock_and_done();
        chk("t4_recover_cur", cur_sel, 1'b0);

        // Pending requests while busy: last one wins
        clear_log();
        req(1'b1);
        req(1'b1);
        req(1'b0);
        wait_writes(4);
        check_writes(0, 1'b1, 2);
        lock_and_done();
        chk("t5_cur", cur_sel, 1'b1);
        tick();
        chk("t5_second_write", mgmt_write, 1'b1);
        chk("t5_second_addr", mgmt_address, 6'h00);
        chk("t5_second_busy", busy, 1'b1);
        wait_writes(8);
        check_writes(4, 1'b0, 2);
        lock_and_done();
        chk("t5_second_cur", cur_sel, 1'b0);

        // Move to PAL so the mid-sequence reset visibly clears cur_sel
        clear_log();
        req(1'b1);
        wait_writes(4);
        lock_and_done();
        chk("t6_pre_cur", cur_sel, 1'b1);

        // Reset during a stalled WR_K
        stall_mode = 1'b1;
        clear_log();
        req(1'b0);
        k = 0;
        while (!(mgmt_write && mgmt_address == 6'h07) && k < 60) begin
            tick();
            k++;
        end
        chk("t6_in_wr_k", mgmt_write && mgmt_address == 6'h07, 1'b1);
        chk("t6_stalled", mgmt_waitrequest, 1'b1);
        #3;
        rst = 1'b1;
        #2;
        chk("t6_write", mgmt_write, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_cur", cur_sel, 1'b0);
        chk("t6_hold", hold_reset, 1'b0);
        chk("t6_addr", mgmt_address, 6'h00);
        w0 = wr_hi;
        repeat (3) tick();
        rst = 1'b0;
        stall_mode = 1'b0;
        repeat (10) tick();
        chk("t6_no_more_writes", wr_hi - w0, 0);
        chk("t6_idle_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
